// File: rtl/skolem_bvult_bvor_checker.sv
// Exhaustive checker for a candidate Skolem function of phi(a,b,y) = ((a | y) <u b).
// Sweeps x = {a,b}, holds each vector LAT+1 cycles, then checks the returned witness.
module skolem_bvult_bvor_checker #(
  parameter int W   = 4,
  parameter int LAT = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  output logic [2*W-1:0] x,
  input  logic [W-1:0]   y,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2*W:0]   fail_cnt,
  output logic [2*W:0]   real_cnt,
  output logic [2*W-1:0] first_cex,
  output logic           cex_valid
);

  localparam int CW = (LAT < 1) ? 1 : $clog2(LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt;
  logic [W-1:0]  y_q;
  logic [W-1:0]  a, b;
  logic          realizable, holds, last_drive, last_vec;

  assign a          = x[2*W-1:W];
  assign b          = x[W-1:0];
  // a|y >= a with equality at y=0, so a witness exists exactly when a <u b.
  assign realizable = (a < b);
  assign holds      = ((a | y_q) < b);
  assign last_drive = (wait_cnt == CW'(LAT));
  assign last_vec   = (x == '1);
  assign pass       = done && (fail_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_DRIVE;
      S_DRIVE: begin
        if (abort)           state_nxt = S_IDLE;
        else if (last_drive) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (abort)         state_nxt = S_IDLE;
        else if (last_vec) state_nxt = S_DONE;
        else               state_nxt = S_DRIVE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x         <= '0;
      y_q       <= '0;
      wait_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail_cnt  <= '0;
      real_cnt  <= '0;
      first_cex <= '0;
      cex_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            x         <= '0;
            wait_cnt  <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            fail_cnt  <= '0;
            real_cnt  <= '0;
            first_cex <= '0;
            cex_valid <= 1'b0;
          end
        end
        S_DRIVE: begin
          if (abort) begin
            busy <= 1'b0;
            done <= 1'b0;
          end else if (last_drive) begin
            y_q      <= y;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          if (abort) begin
            busy <= 1'b0;
            done <= 1'b0;
          end else begin
            if (realizable) real_cnt <= real_cnt + 1'b1;
            if (realizable && !holds) begin
              fail_cnt <= fail_cnt + 1'b1;
              if (!cex_valid) begin
                first_cex <= x;
                cex_valid <= 1'b1;
              end
            end
            if (last_vec) begin
              busy <= 1'b0;
              done <= 1'b1;
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_skolem_bvult_bvor_checker.sv
// Bench for skolem_bvult_bvor_checker: one instance with LAT=0, one with LAT=2,
// each driven by a stub candidate; expected results are queued at start and popped at done.
module tb_skolem_bvult_bvor_checker;
  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [1:0]     start, abort;
  int             mode [2];
  logic [2*W-1:0] p1, p2;

  wire  [2*W-1:0] x         [2];
  wire  [W-1:0]   y         [2];
  wire  [1:0]     busy, done, pass, cex_valid;
  wire  [2*W:0]   fail_cnt  [2];
  wire  [2*W:0]   real_cnt  [2];
  wire  [2*W-1:0] first_cex [2];

  typedef struct {
    int rc;
    int fc;
    int cx;
    int cv;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Stub candidates: 0 -> y=0, 1 -> y=F, 2 -> y=1, 3 -> y=0 when b odd else F.
  function automatic logic [W-1:0] stub(input int m, input logic [2*W-1:0] v);
    logic [W-1:0] bb;
    bb = v[W-1:0];
    case (m)
      0:       return 4'h0;
      1:       return 4'hF;
      2:       return 4'h1;
      default: return bb[0] ? 4'h0 : 4'hF;
    endcase
  endfunction

  // LAT=2 candidate is a two-stage pipeline so a mistimed capture reads a stale vector.
  always @(posedge clk) begin
    p1 <= x[1];
    p2 <= p1;
  end
  assign y[0] = stub(mode[0], x[0]);
  assign y[1] = stub(mode[1], p2);

  skolem_bvult_bvor_checker #(.W(W), .LAT(0)) u_lat0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
    .x(x[0]), .y(y[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .fail_cnt(fail_cnt[0]), .real_cnt(real_cnt[0]),
    .first_cex(first_cex[0]), .cex_valid(cex_valid[0])
  );

  skolem_bvult_bvor_checker #(.W(W), .LAT(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
    .x(x[1]), .y(y[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .fail_cnt(fail_cnt[1]), .real_cnt(real_cnt[1]),
    .first_cex(first_cex[1]), .cex_valid(cex_valid[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input int m, input int lat);
    exp_t e;
    logic [W-1:0] yy;
    e.rc = 0; e.fc = 0; e.cx = 0; e.cv = 0;
    e.cyc = 256 * (lat + 2);
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (a < b) begin
          e.rc++;
          yy = stub(m, 8'(a * 16 + b));
          if ((a | int'(yy)) >= b) begin
            e.fc++;
            if (e.cv == 0) begin
              e.cx = a * 16 + b;
              e.cv = 1;
            end
          end
        end
      end
    end
    return e;
  endfunction

  task automatic check_reset_state(input int d, input string tag);
    chk({tag, "_x"},    x[d], 0);
    chk({tag, "_fail"}, fail_cnt[d], 0);
    chk({tag, "_real"}, real_cnt[d], 0);
    chk({tag, "_cex"},  first_cex[d], 0);
    chk({tag, "_busy"}, busy[d], 0);
    chk({tag, "_done"}, done[d], 0);
    chk({tag, "_pass"}, pass[d], 0);
    chk({tag, "_cexv"}, cex_valid[d], 0);
  endtask

  task automatic run(input int d, input int m, input int pulse_at, input int abort_at,
                     input bit both_abort, input int rst_at, input bit both_start);
    int   lat;
    int   n;
    bit   ended;
    exp_t e;
    lat = (d == 1) ? 2 : 0;
    mode[d] = m;
    q.push_back(model(m, lat));
    @(negedge clk);
    start[d] = 1'b1;
    abort[d] = both_start;
    @(posedge clk);
    #1;
    start[d] = 1'b0;
    abort[d] = 1'b0;
    chk("acc_busy", busy[d], 1);
    chk("acc_done", done[d], 0);
    chk("acc_real", real_cnt[d], 0);
    chk("acc_fail", fail_cnt[d], 0);
    chk("acc_cexv", cex_valid[d], 0);
    chk("acc_x", x[d], 0);
    n = 0;
    ended = 1'b0;
    while (!ended) begin
      @(posedge clk);
      n++;
      #1;
      start[d] = 1'b0;
      abort[d] = 1'b0;
      if (done[d] || n > 5000) begin
        ended = 1'b1;
      end else begin
        if (n <= 12) chk("x_seq", x[d], n / (lat + 2));
        if (n == pulse_at) start[d] = 1'b1;
        if (n == abort_at) begin
          abort[d] = 1'b1;
          start[d] = both_abort;
          @(posedge clk);
          #1;
          start[d] = 1'b0;
          abort[d] = 1'b0;
          chk("abort_busy", busy[d], 0);
          chk("abort_done", done[d], 0);
          repeat (3) @(posedge clk);
          #1;
          chk("abort_idle", busy[d], 0);
          e = q.pop_front();
          return;
        end
        if (n == rst_at) begin
          rst_n = 1'b0;
          #1;
          check_reset_state(d, "async_rst");
          @(negedge clk);
          rst_n = 1'b1;
          e = q.pop_front();
          return;
        end
      end
    end
    e = q.pop_front();
    chk("run_cycles", n, e.cyc);
    chk("run_real", real_cnt[d], e.rc);
    chk("run_fail", fail_cnt[d], e.fc);
    chk("run_cexv", cex_valid[d], e.cv);
    if (e.cv != 0) chk("run_cex", first_cex[d], e.cx);
    chk("run_pass", pass[d], (e.fc == 0) ? 1 : 0);
    chk("run_busy", busy[d], 0);
    chk("run_done", done[d], 1);
  endtask

  initial begin
    start   = 2'b00;
    abort   = 2'b00;
    mode[0] = 0;
    mode[1] = 0;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state(0, "reset0");
    check_reset_state(1, "reset2");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run(0, 0, -1, -1, 0, -1, 0);
    chk("y0_real", real_cnt[0], 120);
    chk("y0_fail", fail_cnt[0], 0);
    chk("y0_pass", pass[0], 1);

    run(0, 1, -1, -1, 0, -1, 0);
    chk("yF_fail", fail_cnt[0], 120);
    chk("yF_cex", first_cex[0], 8'h01);
    chk("yF_pass", pass[0], 0);

    run(1, 2, -1, -1, 0, -1, 0);
    chk("y1_fail", fail_cnt[1], 8);
    chk("y1_cex", first_cex[1], 8'h01);

    run(1, 3, -1, -1, 0, -1, 0);
    chk("bpar_fail", fail_cnt[1], 56);
    chk("bpar_cex", first_cex[1], 8'h02);

    run(0, 1, -1, 100, 0, -1, 0);
    run(0, 1, -1, -1, 0, -1, 0);
    chk("restart_fail", fail_cnt[0], 120);
    chk("restart_cex", first_cex[0], 8'h01);

    run(0, 0, 8, -1, 0, -1, 0);

    run(0, 1, -1, 50, 1, -1, 0);

    run(0, 1, -1, -1, 0, -1, 0);
    run(0, 0, -1, -1, 0, -1, 1);
    chk("both_done_pass", pass[0], 1);

    run(0, 1, -1, -1, 0, 150, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_busy", busy[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
